// File: rtl/uart_cmd_seq.sv
// Plays a byte table out through the uart_tx valid/ready handshake.
// Supports an inter-byte gap, loop or single-pass mode, abort, and byte/pass accounting.
module uart_cmd_seq #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned GAP_W = 16,
  parameter int unsigned XLEN  = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             tbl_wr_en_i,
  input  logic [AW-1:0]    tbl_wr_addr_i,
  input  logic [7:0]       tbl_wr_data_i,
  input  logic [AW:0]      tbl_len_i,
  input  logic [GAP_W-1:0] gap_i,
  input  logic             loop_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             uart_tx_data_rdy_i,
  output logic [7:0]       uart_tx_data_o,
  output logic             uart_tx_data_vld_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [XLEN-1:0]  tx_cnt_o
);

  typedef enum logic [1:0] {StIdle, StFetch, StSend, StGap} state_e;

  state_e           state_q;
  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    idx_q;
  logic [AW:0]      len_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             loop_q;
  logic [7:0]       data_q;
  logic             vld_q;
  logic             busy_q;
  logic             done_q;
  logic [XLEN-1:0]  cnt_q;

  logic   hs;
  logic   last;
  state_e after_send;

  assign hs         = vld_q & uart_tx_data_rdy_i;
  assign last       = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));
  assign after_send = (gap_q != '0) ? StGap : StFetch;

  // Table is not reset; writes are only honoured while idle.
  always_ff @(posedge clk_i) begin
    if (tbl_wr_en_i && (state_q == StIdle)) begin
      mem_q[tbl_wr_addr_i] <= tbl_wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      len_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      loop_q    <= 1'b0;
      data_q    <= 8'h00;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort_i && (state_q != StIdle)) begin
        // A handshake landing on the abort edge still counts.
        state_q <= StIdle;
        vld_q   <= 1'b0;
        busy_q  <= 1'b0;
        if ((state_q == StSend) && hs) begin
          cnt_q <= cnt_q + XLEN'(1);
        end
      end else begin
        case (state_q)
          StIdle: begin
            if (start_i && !abort_i) begin
              len_q  <= tbl_len_i;
              gap_q  <= gap_i;
              loop_q <= loop_i;
              cnt_q  <= '0;
              idx_q  <= '0;
              if (tbl_len_i == '0) begin
                done_q <= 1'b1;
              end else begin
                busy_q  <= 1'b1;
                state_q <= StFetch;
              end
            end
          end
          StFetch: begin
            data_q  <= mem_q[idx_q];
            vld_q   <= 1'b1;
            state_q <= StSend;
          end
          StSend: begin
            if (hs) begin
              vld_q     <= 1'b0;
              cnt_q     <= cnt_q + XLEN'(1);
              gap_cnt_q <= gap_q - GAP_W'(1);
              if (last) begin
                done_q <= 1'b1;
                idx_q  <= '0;
                if (loop_q) begin
                  state_q <= after_send;
                end else begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
                end
              end else begin
                idx_q   <= idx_q + AW'(1);
                state_q <= after_send;
              end
            end
          end
          StGap: begin
            if (gap_cnt_q == '0) begin
              state_q <= StFetch;
            end else begin
              gap_cnt_q <= gap_cnt_q - GAP_W'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign uart_tx_data_o     = data_q;
  assign uart_tx_data_vld_o = vld_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign tx_cnt_o           = cnt_q;

endmodule

// File: tb/tb_uart_cmd_seq.sv
// Directed bench for uart_cmd_seq: single pass, gap timing, stall, loop/abort,
// zero length, busy-time writes/starts and mid-sequence reset.
module tb_uart_cmd_seq;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;
  localparam int unsigned GAP_W = 16;
  localparam int unsigned XLEN  = 32;

  logic             clk_i = 1'b0;
  logic             rst_n_i = 1'b0;
  logic             tbl_wr_en_i = 1'b0;
  logic [AW-1:0]    tbl_wr_addr_i = '0;
  logic [7:0]       tbl_wr_data_i = '0;
  logic [AW:0]      tbl_len_i = '0;
  logic [GAP_W-1:0] gap_i = '0;
  logic             loop_i = 1'b0;
  logic             start_i = 1'b0;
  logic             abort_i = 1'b0;
  logic             uart_tx_data_rdy_i = 1'b1;
  logic [7:0]       uart_tx_data_o;
  logic             uart_tx_data_vld_o;
  logic             busy_o;
  logic             done_o;
  logic [XLEN-1:0]  tx_cnt_o;

  int vecs = 0;
  int errs = 0;

  logic [7:0] tbl [19] = '{8'h2a, 8'h2c, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0f, 8'h00, 8'h00, 8'h00,
                           8'h2e, 8'h23, 8'ha0, 8'h84, 8'h00, 8'h0f, 8'h00, 8'hf0, 8'h2b};

  uart_cmd_seq #(.DEPTH(DEPTH), .AW(AW), .GAP_W(GAP_W), .XLEN(XLEN)) dut (
    .clk_i              (clk_i),
    .rst_n_i            (rst_n_i),
    .tbl_wr_en_i        (tbl_wr_en_i),
    .tbl_wr_addr_i      (tbl_wr_addr_i),
    .tbl_wr_data_i      (tbl_wr_data_i),
    .tbl_len_i          (tbl_len_i),
    .gap_i              (gap_i),
    .loop_i             (loop_i),
    .start_i            (start_i),
    .abort_i            (abort_i),
    .uart_tx_data_rdy_i (uart_tx_data_rdy_i),
    .uart_tx_data_o     (uart_tx_data_o),
    .uart_tx_data_vld_o (uart_tx_data_vld_o),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .tx_cnt_o           (tx_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
    tbl_wr_en_i = 1'b1; tbl_wr_addr_i = a; tbl_wr_data_i = d;
    tick();
    tbl_wr_en_i = 1'b0;
  endtask

  task automatic pulse_start(input int len, input int gap, input logic lp);
    tbl_len_i = (AW+1)'(len); gap_i = GAP_W'(gap); loop_i = lp; start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Counts low samples until vld rises, bounded.
  task automatic wait_vld(output int lows);
    lows = 0;
    while (uart_tx_data_vld_o !== 1'b1 && lows < 200) begin
      lows++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    tick(); tick();
    vecs++; if (uart_tx_data_o !== 8'h00) begin errs++; $display("FAIL reset_data: got %h want 00", uart_tx_data_o); end
    vecs++; if (uart_tx_data_vld_o !== 1'b0) begin errs++; $display("FAIL reset_vld: got %b want 0", uart_tx_data_vld_o); end
    vecs++; if (busy_o !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    vecs++; if (done_o !== 1'b0) begin errs++; $display("FAIL reset_done: got %b want 0", done_o); end
    vecs++; if (tx_cnt_o !== 32'd0) begin errs++; $display("FAIL reset_cnt: got %0d want 0", tx_cnt_o); end
    rst_n_i = 1'b1;
    tick();
  endtask

  task automatic test_single_pass();
    for (int i = 0; i < 19; i++) wr(AW'(i), tbl[i]);
    uart_tx_data_rdy_i = 1'b1;
    pulse_start(19, 0, 1'b0);
    vecs++; if (uart_tx_data_vld_o !== 1'b0) begin errs++; $display("FAIL sp_fetch_vld: got %b want 0", uart_tx_data_vld_o); end
    vecs++; if (busy_o !== 1'b1) begin errs++; $display("FAIL sp_busy: got %b want 1", busy_o); end
    tick();
    for (int i = 0; i < 19; i++) begin
      vecs++; if (uart_tx_data_vld_o !== 1'b1) begin errs++; $display("FAIL sp_vld[%0d]: got %b want 1", i, uart_tx_data_vld_o); end
      vecs++; if (uart_tx_data_o !== tbl[i]) begin errs++; $display("FAIL sp_data[%0d]: got %h want %h", i, uart_tx_data_o, tbl[i]); end
      tick();
      vecs++; if (uart_tx_data_vld_o !== 1'b0) begin errs++; $display("FAIL sp_low[%0d]: got %b want 0", i, uart_tx_data_vld_o); end
      vecs++; if (tx_cnt_o !== 32'(i + 1)) begin errs++; $display("FAIL sp_cnt[%0d]: got %0d want %0d", i, tx_cnt_o, i + 1); end
      vecs++; if (done_o !== (i == 18)) begin errs++; $display("FAIL sp_done[%0d]: got %b want %b", i, done_o, i == 18); end
      if (i < 18) tick();
    end
    tick();
    vecs++; if (done_o !== 1'b0) begin errs++; $display("FAIL sp_done_end: got %b want 0", done_o); end
    vecs++; if (busy_o !== 1'b0) begin errs++; $display("FAIL sp_busy_end: got %b want 0", busy_o); end
    vecs++; if (tx_cnt_o !== 32'd19) begin errs++; $display("FAIL sp_cnt_end: got %0d want 19", tx_cnt_o); end
  endtask

  task automatic test_gap();
    int n;
    pulse_start(4, 5, 1'b0);
    vecs++; if (uart_tx_data_vld_o !== 1'b0) begin errs++; $display("FAIL gap_e0_vld: got %b want 0", uart_tx_data_vld_o); end
    tick();
    for (int i = 0; i < 4; i++) begin
      vecs++; if (uart_tx_data_vld_o !== 1'b1) begin errs++; $display("FAIL gap_vld[%0d]: got %b want 1", i, uart_tx_data_vld_o); end
      vecs++; if (uart_tx_data_o !== tbl[i]) begin errs++; $display("FAIL gap_data[%0d]: got %h want %h", i, uart_tx_data_o, tbl[i]); end
      tick();
      if (i < 3) begin
        wait_vld(n);
        vecs++; if (n != 6) begin errs++; $display("FAIL gap_lows[%0d]: got %0d want 6", i, n); end
      end else begin
        vecs++; if (done_o !== 1'b1) begin errs++; $display("FAIL gap_done: got %b want 1", done_o); end
      end
    end
    tick();
    vecs++; if (busy_o !== 1'b0) begin errs++; $display("FAIL gap_busy_end: got %b want 0", busy_o); end
  endtask

  task automatic test_rdy_stall();
    int n;
    uart_tx_data_rdy_i = 1'b1;
    pulse_start(4, 0, 1'b0);
    tick();
    tick();
    uart_tx_data_rdy_i = 1'b0;
    tick();
    for (int c = 0; c < 100; c++) begin
      vecs++; if (uart_tx_data_vld_o !== 1'b1 || uart_tx_data_o !== tbl[1] || tx_cnt_o !== 32'd1) begin
        errs++;
        $display("FAIL stall[%0d]: got vld=%b data=%h cnt=%0d want vld=1 data=%h cnt=1",
                 c, uart_tx_data_vld_o, uart_tx_data_o, tx_cnt_o, tbl[1]);
      end
      tick();
    end
    uart_tx_data_rdy_i = 1'b1;
    tick();
    vecs++; if (tx_cnt_o !== 32'd2) begin errs++; $display("FAIL stall_release_cnt: got %0d want 2", tx_cnt_o); end
    n = 0;
    while (done_o !== 1'b1 && n < 50) begin n++; tick(); end
    vecs++; if (done_o !== 1'b1) begin errs++; $display("FAIL stall_done: got %b want 1 (timeout)", done_o); end
    vecs++; if (tx_cnt_o !== 32'd4) begin errs++; $display("FAIL stall_cnt_end: got %0d want 4", tx_cnt_o); end
    tick();
  endtask

  task automatic test_loop_abort();
    int dcnt = 0;
    pulse_start(3, 0, 1'b1);
    tick();
    for (int k = 0; k < 7; k++) begin
      vecs++; if (uart_tx_data_vld_o !== 1'b1 || uart_tx_data_o !== tbl[k % 3]) begin
        errs++;
        $display("FAIL loop_byte[%0d]: got vld=%b data=%h want vld=1 data=%h",
                 k, uart_tx_data_vld_o, uart_tx_data_o, tbl[k % 3]);
      end
      if (k == 6) abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      if (k < 6) begin
        if (done_o === 1'b1) dcnt++;
        tick();
      end
    end
    vecs++; if (uart_tx_data_vld_o !== 1'b0) begin errs++; $display("FAIL abort_vld: got %b want 0", uart_tx_data_vld_o); end
    vecs++; if (busy_o !== 1'b0) begin errs++; $display("FAIL abort_busy: got %b want 0", busy_o); end
    vecs++; if (done_o !== 1'b0) begin errs++; $display("FAIL abort_done: got %b want 0", done_o); end
    vecs++; if (tx_cnt_o !== 32'd7) begin errs++; $display("FAIL abort_cnt: got %0d want 7", tx_cnt_o); end
    vecs++; if (dcnt != 2) begin errs++; $display("FAIL loop_done_pulses: got %0d want 2", dcnt); end
    for (int c = 0; c < 5; c++) begin
      tick();
      vecs++; if (uart_tx_data_vld_o !== 1'b0 || done_o !== 1'b0) begin
        errs++; $display("FAIL post_abort[%0d]: got vld=%b done=%b want 0 0", c, uart_tx_data_vld_o, done_o);
      end
    end
  endtask

  task automatic test_len_zero();
    pulse_start(0, 0, 1'b0);
    vecs++; if (done_o !== 1'b1) begin errs++; $display("FAIL len0_done: got %b want 1", done_o); end
    vecs++; if (busy_o !== 1'b0) begin errs++; $display("FAIL len0_busy: got %b want 0", busy_o); end
    vecs++; if (tx_cnt_o !== 32'd0) begin errs++; $display("FAIL len0_cnt: got %0d want 0", tx_cnt_o); end
    tick();
    vecs++; if (done_o !== 1'b0 || uart_tx_data_vld_o !== 1'b0) begin
      errs++; $display("FAIL len0_after: got done=%b vld=%b want 0 0", done_o, uart_tx_data_vld_o);
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    int seen = 0;
    pulse_start(3, 3, 1'b0);
    tick();
    vecs++; if (uart_tx_data_o !== 8'h2a) begin errs++; $display("FAIL bi_byte0: got %h want 2a", uart_tx_data_o); end
    tick();
    tbl_wr_en_i = 1'b1; tbl_wr_addr_i = '0; tbl_wr_data_i = 8'h55;
    tbl_len_i = 7'd1; gap_i = '0; loop_i = 1'b1; start_i = 1'b1;
    tick();
    tbl_wr_en_i = 1'b0; start_i = 1'b0;
    wait_vld(n);
    vecs++; if (n != 3) begin errs++; $display("FAIL bi_gap_kept: got %0d lows want 3", n); end
    vecs++; if (uart_tx_data_o !== 8'h2c) begin errs++; $display("FAIL bi_byte1: got %h want 2c", uart_tx_data_o); end
    tick();
    wait_vld(n);
    vecs++; if (n != 4) begin errs++; $display("FAIL bi_gap2: got %0d lows want 4", n); end
    vecs++; if (uart_tx_data_o !== 8'h00) begin errs++; $display("FAIL bi_byte2: got %h want 00", uart_tx_data_o); end
    tick();
    vecs++; if (done_o !== 1'b1) begin errs++; $display("FAIL bi_done: got %b want 1", done_o); end
    vecs++; if (tx_cnt_o !== 32'd3) begin errs++; $display("FAIL bi_cnt: got %0d want 3", tx_cnt_o); end
    for (int c = 0; c < 10; c++) begin
      tick();
      if (uart_tx_data_vld_o !== 1'b0 || busy_o !== 1'b0) seen++;
    end
    vecs++; if (seen != 0) begin errs++; $display("FAIL bi_no_loop: got %0d active cycles want 0", seen); end
    pulse_start(1, 0, 1'b0);
    tick();
    vecs++; if (uart_tx_data_o !== 8'h2a) begin errs++; $display("FAIL bi_table_kept: got %h want 2a", uart_tx_data_o); end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    uart_tx_data_rdy_i = 1'b1;
    pulse_start(4, 0, 1'b0);
    tick();
    tick();
    uart_tx_data_rdy_i = 1'b0;
    tick();
    rst_n_i = 1'b0;
    tick();
    vecs++; if (uart_tx_data_vld_o !== 1'b0) begin errs++; $display("FAIL rm_vld: got %b want 0", uart_tx_data_vld_o); end
    vecs++; if (busy_o !== 1'b0) begin errs++; $display("FAIL rm_busy: got %b want 0", busy_o); end
    vecs++; if (tx_cnt_o !== 32'd0) begin errs++; $display("FAIL rm_cnt: got %0d want 0", tx_cnt_o); end
    rst_n_i = 1'b1;
    uart_tx_data_rdy_i = 1'b1;
    pulse_start(4, 0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      vecs++; if (uart_tx_data_vld_o !== 1'b1 || uart_tx_data_o !== tbl[i]) begin
        errs++;
        $display("FAIL rm_replay[%0d]: got vld=%b data=%h want vld=1 data=%h",
                 i, uart_tx_data_vld_o, uart_tx_data_o, tbl[i]);
      end
      tick();
      if (i < 3) tick();
    end
    vecs++; if (done_o !== 1'b1) begin errs++; $display("FAIL rm_done: got %b want 1", done_o); end
    vecs++; if (tx_cnt_o !== 32'd4) begin errs++; $display("FAIL rm_cnt_end: got %0d want 4", tx_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_gap();
    test_rdy_stall();
    test_loop_abort();
    test_len_zero();
    test_busy_ignore();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/uart_cmd_seq.md
Name: uart_cmd_seq

Overview:
- Synthesizable UART command sequencer: holds a byte table of up to DEPTH entries and plays it out through the uart_tx data/valid/ready handshake.
- Supports a programmable inter-byte gap, single-pass or loop mode, abort, and byte/pass accounting.
- Sits in front of a uart_tx instance. It replaces hand-coded command streams (CPU_RST / CONF_WR / DATA_WR / CPU_RUN boot sequences) for both bench and on-chip self-boot use.

Parameters:
DEPTH, 64, table entries (power of two, >=2)
AW, $clog2(DEPTH), table address width
GAP_W, 16, inter-byte gap counter width
XLEN, 32, width of byte counter output

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  reset, synchronous, active-low
tbl_wr_en_i  in  1  table write strobe
tbl_wr_addr_i  in  AW  table write address
tbl_wr_data_i  in  8  table write data
tbl_len_i  in  AW+1  entries per pass, 0..DEPTH, sampled at start
gap_i  in  GAP_W  idle cycles between bytes, sampled at start
loop_i  in  1  1 = repeat table until abort, sampled at start
start_i  in  1  start pulse
abort_i  in  1  stop playback
uart_tx_data_rdy_i  in  1  uart_tx ready
uart_tx_data_o  out  8  byte to uart_tx
uart_tx_data_vld_o  out  1  byte valid
busy_o  out  1  sequence active
done_o  out  1  one-cycle pulse at end of each pass
tx_cnt_o  out  XLEN  bytes accepted since last start

Behaviour:
- Reset: all regs synchronous on clk_i rising edge when rst_n_i=0.
  - Outputs: uart_tx_data_o=8'h00, uart_tx_data_vld_o=0, busy_o=0, done_o=0, tx_cnt_o=0.
  - State=IDLE, index=0. Table contents are not reset.
- Table: DEPTH x 8 with synchronous read.
  - A write is accepted only when tbl_wr_en_i=1 and state=IDLE; writes while busy are ignored.
- State machine: IDLE, FETCH, SEND, GAP.
  - IDLE: on start_i=1, latch tbl_len_i, gap_i, loop_i; clear tx_cnt_o; index=0; busy_o=1.
    - Len=0: stay IDLE, busy_o=0, pulse done_o next cycle, no bytes sent.
    - Otherwise go to FETCH.
  - FETCH: issue table read at index, go to SEND.
  - SEND: uart_tx_data_o=table[index], uart_tx_data_vld_o=1, both held stable until handshake.
    - Handshake: vld_o=1 and rdy_i=1 sampled on the same edge. On handshake: vld_o=0 next cycle, tx_cnt_o+1 (wraps modulo 2^XLEN).
    - If index=len-1: done_o pulses one cycle. If loop=1, index=0 and continue; else go IDLE with busy_o=0.
    - Otherwise index+1.
    - Next state: GAP if gap>0, else FETCH.
  - GAP: count gap cycles from gap-1 down to 0, then FETCH.
- Latency:
  - start sampled at edge E0 -> vld_o high after E1 -> byte visible 2 edges after start.
  - Back-to-back with gap=0 and rdy stuck high: vld_o high 1 cycle, low 1 cycle (FETCH).
  - gap=G adds exactly G low cycles.
- start_i while busy is ignored; latched config is unchanged.
- abort_i while busy:
  - Next edge: vld_o=0, state=IDLE, busy_o=0, no done_o.
  - tx_cnt_o holds its value; a byte whose handshake coincides with abort is counted.
  - abort_i has priority over start_i in the same cycle.
- Loop wrap: done_o pulses every pass; tx_cnt_o keeps counting across passes.
- tbl_len_i=DEPTH plays all entries; index wraps from DEPTH-1 to 0 without overflow.
- rdy_i dropping while vld_o=1: hold data and vld, no count.
- Reset mid-sequence: returns to IDLE the next edge; table contents are retained.

Test Plan:
- Load 19 bytes {2a,2c,00,00,00,00,0f,00,00,00,2e,23,a0,84,00,0f,00,f0,2b}, len=19, gap=0, loop=0, rdy=1 -> 19 handshakes in order; vld toggles 1/0; done_o pulse on byte 19; tx_cnt_o=19; busy_o=0 one cycle after done.
- len=4, gap=5, rdy=1 -> exactly 5 idle cycles plus 1 FETCH cycle between vld pulses; first vld 2 edges after start.
- rdy held low 100 cycles during byte 2 -> data_o=table[1] stable, vld_o=1 throughout, tx_cnt_o stays 1 until rdy rises.
- loop=1, len=3, abort after 7 handshakes -> bytes t0,t1,t2,t0,t1,t2,t0; done_o pulses twice; vld_o=0 next edge after abort; tx_cnt_o=7; no third done.
- len=0 start -> no vld, done_o pulse; table write and start_i while busy -> ignored, table and config unchanged.
- rst_n_i=0 during SEND -> next edge vld_o=0, busy_o=0, tx_cnt_o=0; a restart replays the unchanged table.
